// File: rtl/geo_page_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : geo_page_stepper
//  Brief    : GeoRAM-style page register pair ({Block,Window}) with an
//             auto-stepping engine. Each access to the last byte of the
//             $DExx window ($DEFF) while running advances the 14-bit page
//             by +/-1 and decrements a pages-remaining counter. The
//             interrupt output is present only when GEO_STEP_IRQ_EN is
//             defined. Otherwise nIRQ is tied high.
//  Clocking : all state updates on the falling edge of PHI2; RESET is
//             asynchronous and active high.
//  Revision : 1.0 - initial release
// ============================================================================
module geo_page_stepper (
    input  logic       PHI2,
    input  logic       RESET,
    input  logic       RegSEL,
    input  logic       IOSEL,
    input  logic       nWE,
    input  logic [7:0] A,
    input  logic [7:0] WRD,
    output logic [7:0] Block,
    output logic [5:0] Window,
    output logic [7:0] RDD,
    output logic       RDOE,
    output logic       nIRQ
);

    // Register offsets within the $DFxx page
    localparam logic [7:0] C_ADDR_BLOCK  = 8'hFF;
    localparam logic [7:0] C_ADDR_WINDOW = 8'hFE;
    localparam logic [7:0] C_ADDR_CTRL   = 8'hFD;
    localparam logic [7:0] C_ADDR_COUNT  = 8'hFC;
    // Last byte of the $DExx window, the auto-step trigger address
    localparam logic [7:0] C_ADDR_STEP   = 8'hFF;
    localparam logic [13:0] C_PAGE_MAX   = 14'h3FFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state, w_stateNext;
    logic [13:0] r_page,  w_pageNext;    // {Block, Window} as one value
    logic [7:0]  r_count, w_countNext;
    logic        r_en,    w_enNext;
    logic        r_dir,   w_dirNext;
    logic        r_done,  w_doneNext;
    logic        r_wrap,  w_wrapNext;

    logic        w_regWrite;
    logic        w_step;
    logic        w_readHit;

    // A register write wins over a simultaneous window access
    assign w_regWrite = RegSEL & ~nWE;
    assign w_step     = IOSEL & (A == C_ADDR_STEP) & (r_state == ST_RUN) & ~w_regWrite;
    assign w_readHit  = RegSEL & nWE & ((A == C_ADDR_CTRL) | (A == C_ADDR_COUNT));

    assign Block  = r_page[13:6];
    assign Window = r_page[5:0];

    // Next-state and datapath: register writes first, then the auto-step
    always_comb begin
        w_stateNext = r_state;
        w_pageNext  = r_page;
        w_countNext = r_count;
        w_enNext    = r_en;
        w_dirNext   = r_dir;
        w_doneNext  = r_done;
        w_wrapNext  = r_wrap;

        if (w_regWrite) begin
            case (A)
                C_ADDR_BLOCK:  w_pageNext[13:6] = WRD;
                C_ADDR_WINDOW: w_pageNext[5:0]  = WRD[5:0];
                C_ADDR_COUNT:  w_countNext      = WRD;
                C_ADDR_CTRL: begin
                    // Flag clear is applied before anything can set them again
                    if (WRD[7]) begin
                        w_doneNext = 1'b0;
                        w_wrapNext = 1'b0;
                    end
                    w_enNext  = WRD[0];
                    w_dirNext = WRD[1];
                    if (WRD[0]) begin
                        if (r_count != 8'd0) begin
                            w_stateNext = ST_RUN;
                        end else begin
                            w_stateNext = ST_DONE;
                            w_doneNext  = 1'b1;
                        end
                    end else begin
                        w_stateNext = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end

        if (w_step) begin
            if (r_dir) begin
                w_pageNext = r_page - 14'd1;
                if (r_page == 14'd0) w_wrapNext = 1'b1;
            end else begin
                w_pageNext = r_page + 14'd1;
                if (r_page == C_PAGE_MAX) w_wrapNext = 1'b1;
            end
            w_countNext = r_count - 8'd1;
            if (r_count == 8'd1) begin
                w_doneNext  = 1'b1;
                w_stateNext = ST_DONE;
            end
        end
    end

    // State register, updated on the falling edge of PHI2
    always_ff @(negedge PHI2 or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_page  <= 14'd0;
            r_count <= 8'd0;
            r_en    <= 1'b0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_page  <= w_pageNext;
            r_count <= w_countNext;
            r_en    <= w_enNext;
            r_dir   <= w_dirNext;
            r_done  <= w_doneNext;
            r_wrap  <= w_wrapNext;
        end
    end

    // Register read mux; the bus is released entirely during reset
    always_comb begin
        RDD  = 8'd0;
        RDOE = 1'b0;
        if (w_readHit && !RESET) begin
            RDOE = 1'b1;
            if (A == C_ADDR_CTRL) RDD = {r_done, r_wrap, 4'b0000, r_dir, r_en};
            else                  RDD = r_count;
        end
    end

`ifdef GEO_STEP_IRQ_EN
    // Interrupt follows the DONE flag
    assign nIRQ = ~r_done;
`else
    assign nIRQ = 1'b1;
`endif

endmodule
`default_nettype wire

// File: doc/geo_page_stepper.md
GEO_PAGE_STEPPER -- requirements
Module: geo_page_stepper

Interface
REQ-001 SHALL have these ports, all state clocked on the falling edge of PHI2:
- PHI2  in  1  C64 PHI2 clock, the only clock.
- RESET  in  1  active-high reset, asynchronous assert.
- RegSEL  in  1  $DFxx register page select.
- IOSEL  in  1  $DExx window access select.
- nWE  in  1  C64 write strobe, active low.
- A  in  8  C64 A[7:0].
- WRD  in  8  write data from C64.
- Block  out  8  current 16 KB block number.
- Window  out  6  current 256-byte window within the block.
- RDD  out  8  register read data.
- RDOE  out  1  RDD valid; drive the data bus when high.
- nIRQ  out  1  interrupt request, active low.
REQ-002 SHALL decode the full A[7:0] under RegSEL: $FF Block, $FE Window, $FD CTRL/STAT, $FC COUNT; other offsets SHALL have no effect.

Function
REQ-003 SHALL load Block from WRD[7:0] on a write to $FF, and Window from WRD[5:0] on a write to $FE.
REQ-004 SHALL decode CTRL writes as: bit0 EN (auto-step), bit1 DIR (0 = up, 1 = down), bit7 = 1 clears DONE and WRAP, bits 6:2 ignored.
REQ-005 SHALL return STAT on a read of $FD: bit7 DONE, bit6 WRAP, bit1 DIR, bit0 EN, others 0.
REQ-006 SHALL load COUNT (8-bit pages remaining) on a write to $FC, and return COUNT on a read of $FC.
REQ-007 SHALL assert RDOE combinationally when RegSEL, nWE and A is $FD or $FC; otherwise RDOE=0 and RDD=0.
REQ-008 SHALL implement FSM states IDLE, RUN and DONE.
REQ-009 SHALL make these transitions:
- CTRL write with EN=1: RUN if COUNT≠0, else DONE with DONE flag set.
- CTRL write with EN=0: IDLE from any state.
REQ-010 SHALL define a step trigger as: IOSEL high and A=$FF (last byte of the window) in state RUN, evaluated on the falling edge that ends that cycle, read or write.
REQ-011 SHALL, on a step, advance {Block,Window} by ±1 as a 14-bit value per DIR, and decrement COUNT, all on the same edge; the new page SHALL be visible in the next cycle.
REQ-012 SHALL handle wrap:
- Up from Block=$FF, Window=63: go to 0/0 and set WRAP.
- Down from 0/0: go to $FF/63 and set WRAP.
- Stepping SHALL continue after a wrap.
REQ-013 SHALL, when a step makes COUNT reach 0, set DONE and move to state DONE; no further steps SHALL occur until CTRL is rewritten.
REQ-014 SHALL give a register write (RegSEL with nWE low) priority if RegSEL and IOSEL are both high in one cycle: the write occurs and the step is suppressed, with COUNT unchanged.
REQ-015 SHALL clear flags and set bits on the same edge as follows: bit7 clears first, then a step on that edge may set the flags again.
REQ-016 SHALL NOT change COUNT, DIR or EN on its own, except for the COUNT decrement in REQ-011.

Reset
REQ-017 SHALL, while RESET is high, immediately clear Block, Window, COUNT, EN, DIR, DONE and WRAP, with FSM=IDLE, nIRQ=1 and RDOE=0.
REQ-018 SHALL, on RESET release, take its first state update at the next PHI2 falling edge.
REQ-019 SHALL, if RESET occurs mid-RUN, abandon the run with no partial step.

Configuration
REQ-020 SHALL, with GEO_STEP_IRQ_EN defined, drive nIRQ=0 while DONE=1; nIRQ SHALL release on the edge where CTRL bit7 clears DONE.
REQ-021 SHALL, with GEO_STEP_IRQ_EN undefined, hold nIRQ constant 1 and include no interrupt logic; all other behaviour SHALL be unchanged.

Verification
REQ-022 SHALL cover these directed scenarios:
- Basic step: write Block=$10, Window=5, COUNT=2, CTRL=$01, then read $DEFF → next cycle Window=6, COUNT=1, state RUN.
- Run completion: after that, access $DEFF twice more → Window=7, COUNT=0, DONE=1, STAT=$81, nIRQ=0 (IRQ build); the second access leaves the page unchanged.
- Up wrap: Block=$FF, Window=63, COUNT=1, CTRL=$01, access $DEFF → Block=0, Window=0, STAT=$C1; then CTRL=$80 → STAT=$00, nIRQ=1.
- Down carry: Block=$20, Window=0, COUNT=3, CTRL=$03, access $DEFF → Block=$1F, Window=63, COUNT=2.
- Gating: access $DEFE in RUN → no step; access $DEFF in IDLE → no step; write COUNT=0 then CTRL=$01 → DONE immediately with no page change.
- Reset mid-run: assert RESET asynchronously in RUN → all outputs 0 and nIRQ=1 before the next edge; no step occurs on the first edge after release.
